tdp_ram_16x8: RTL and testbench
===============================

Name:
tdp_ram_16x8

Overview:
- True dual-port synchronous RAM: 16 words x 8 bits, two fully independent read/write ports sharing one clock.
- Each port has a bidirectional 8-bit data bus, a 4-bit address, and separate write-enable and read-enable strobes.
- Used as a small local scratch store where two agents need concurrent access; the RAM drives a port's bus only during that port's read.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all activity on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_0  inout  DATA_W  port 0 bus: the RAM samples it on a write and drives it on a read.
- data_1  inout  DATA_W  port 1 bus: same rules as data_0.
- addr_0  input  ADDR_W  port 0 word address.
- addr_1  input  ADDR_W  port 1 word address.
- we_0  input  1  port 0 write enable.
- we_1  input  1  port 1 write enable.
- re_0  input  1  port 0 read enable.
- re_1  input  1  port 1 read enable.

Behaviour:
- Reset (rst=1 at a rising clk edge):
  - All 16 words clear to 0; both read registers clear to 0.
  - Reset has priority over every write and read in the same cycle.
  - Reset asserted mid-operation discards the pending access.
- Per-port command decode, each port independent:
  - we=1, re=0: write. mem[addr] <= data on the rising edge. The RAM does not drive the bus.
  - we=0, re=1: read. The read register loads mem[addr] on the rising edge. The RAM drives the bus with the read register while re=1 and we=0. Latency: data is valid 1 cycle after the address is sampled.
  - we=0, re=0: idle. Bus is high-Z; the read register holds its value.
  - we=1, re=1: illegal, treated as idle. No write, no read-register update, bus high-Z.
- Bus drive condition is purely combinational on (re && !we). Outside that condition the RAM never drives the bus, so the external agent can drive it whenever we && !re.
- Cross-port collisions in the same cycle:
  - Both ports write the same address: port 0 data wins.
  - One port reads an address the other port writes: the read returns the old contents (read-first). The new data is visible from the next cycle.
  - Both ports read the same address: both return the same word.
- Address range 0..15 is fully decoded; no out-of-range case exists.

Optional Feature:
- Macro: TDP_RAM_COLLISION_DETECT_EN.
- Defined:
  - Adds output port collision (1 bit).
  - collision is registered: it is high for exactly one cycle after any edge where both ports issued a write (we=1, re=0) to the same address.
  - collision clears to 0 on reset.
  - Write resolution is unchanged: port 0 still wins.
- Undefined: the port does not exist and there is no detection logic.

Decomposition:
- Package tdp_ram_pkg holds:
  - DATA_W, ADDR_W, DEPTH localparam defaults.
  - typedef word_t (logic [DATA_W-1:0]).
  - typedef addr_t (logic [ADDR_W-1:0]).
  - Enum port_cmd_e {IDLE, WRITE, READ, ILLEGAL}, decoded from {we, re}.
- Sub-module tdp_ram_port, instantiated twice:
  - Inputs: the port's we/re.
  - Outputs: the decoded command.
  - Contains the read register, the tri-state driver and the bus sample path.
- The memory array and collision arbitration live in the top module.

Test Plan:
- Reset: assert rst for 2 cycles, release, then read addr 5 on port 0 -> data_0 = 0x00 one cycle later.
- Interleaved writes: port 0 writes i*i to even addresses 0..14; port 1 writes j*j to odd addresses 1..15, in parallel. Then:
  - port 0 reads 15,13,...,1 -> 225,169,121,81,49,25,9,1.
  - port 1 reads 14,12,...,0 -> 196,144,100,64,36,16,4,0.
  - Each value appears 1 cycle after its address.
- Bus release: whenever a port is idle, writing, or has we=re=1, the RAM drives high-Z on that port's bus. Check the bus reads Z with no external driver.
- Write collision: both ports write addr 3 (port 0 0xAA, port 1 0x55) -> a later read returns 0xAA. With TDP_RAM_COLLISION_DETECT_EN, collision pulses high for exactly 1 cycle.
- Read-during-write: addr 7 holds 49; in one cycle port 1 writes 0x77 to addr 7 while port 0 reads addr 7. Port 0 returns 49; the next port 0 read of addr 7 returns 0x77.
- Reset mid-write: port 0 writes 0x99 to addr 2 in the same cycle rst=1 -> addr 2 reads 0x00 afterwards.

Source files
------------

// File: rtl/tdp_ram_pkg.sv
// rtl/tdp_ram_pkg.sv - shared sizes, types and command decode for tdp_ram_16x8
package tdp_ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    ILLEGAL = 2'd3
  } port_cmd_e;

  // we and re together is illegal; callers treat ILLEGAL exactly like IDLE.
  function automatic port_cmd_e decode_cmd(input logic we, input logic re);
    case ({we, re})
      2'b10:   return WRITE;
      2'b01:   return READ;
      2'b11:   return ILLEGAL;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tdp_ram_port.sv
// rtl/tdp_ram_port.sv - one RAM port: command decode, read register, bus driver
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   we, re    : port strobes
//   mem_word  : current contents of mem[addr] for this port (old data on collision)
//   cmd       : decoded command, used by the array for write control
//   wr_word   : value sampled from the bus for writes
//   data      : bidirectional bus, driven only while cmd == READ
module tdp_ram_port
  import tdp_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  word_t             mem_word,
  output port_cmd_e         cmd,
  output word_t             wr_word,
  inout  wire  [DATA_W-1:0] data
);

  word_t rd_q;

  assign cmd = decode_cmd(we, re);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (cmd == READ) begin
      rd_q <= mem_word;
    end
  end

  // Drive follows the live strobes, not a registered copy, so the bus is
  // released in the same cycle re drops or we rises.
  assign data    = (cmd == READ) ? rd_q : {DATA_W{1'bz}};
  assign wr_word = data;

endmodule

// File: rtl/tdp_ram_16x8.sv
// rtl/tdp_ram_16x8.sv - true dual-port 16x8 synchronous RAM with bidirectional buses
//
// Optional feature macro: TDP_RAM_COLLISION_DETECT_EN adds the collision output.
//
// Ports:
//   clk, rst         : shared clock, synchronous active-high reset (clears array and read registers)
//   collision        : (macro only) one-cycle pulse after both ports write the same address
//   data_0, data_1   : port buses, sampled on write, driven on read
//   addr_0, addr_1   : word addresses
//   we_0, we_1       : write enables
//   re_0, re_1       : read enables
module tdp_ram_16x8
  import tdp_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef TDP_RAM_COLLISION_DETECT_EN
  output logic              collision,
`endif
  inout  wire  [DATA_W-1:0] data_0,
  inout  wire  [DATA_W-1:0] data_1,
  input  addr_t             addr_0,
  input  addr_t             addr_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic              re_0,
  input  logic              re_1
);

  word_t     mem [DEPTH];
  port_cmd_e cmd_0, cmd_1;
  word_t     wr_word_0, wr_word_1;

  tdp_ram_port u_port_0 (
    .clk      (clk),
    .rst      (rst),
    .we       (we_0),
    .re       (re_0),
    .mem_word (mem[addr_0]),
    .cmd      (cmd_0),
    .wr_word  (wr_word_0),
    .data     (data_0)
  );

  tdp_ram_port u_port_1 (
    .clk      (clk),
    .rst      (rst),
    .we       (we_1),
    .re       (re_1),
    .mem_word (mem[addr_1]),
    .cmd      (cmd_1),
    .wr_word  (wr_word_1),
    .data     (data_1)
  );

  // Port 1 is applied first so port 0's assignment lands last and wins a
  // same-address write. Read registers sample mem before this update,
  // giving read-first behaviour across ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (cmd_1 == WRITE) begin
        mem[addr_1] <= wr_word_1;
      end
      if (cmd_0 == WRITE) begin
        mem[addr_0] <= wr_word_0;
      end
    end
  end

`ifdef TDP_RAM_COLLISION_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      collision <= 1'b0;
    end else begin
      collision <= (cmd_0 == WRITE) && (cmd_1 == WRITE) && (addr_0 == addr_1);
    end
  end
`else
  // Without the macro there is no collision output and no detection logic.
`endif

endmodule

// File: tb/tb_tdp_ram_16x8.sv
// tb/tb_tdp_ram_16x8.sv - directed scoreboard bench for tdp_ram_16x8
module tb_tdp_ram_16x8;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr_0, addr_1;
  logic       we_0, we_1, re_0, re_1;
  logic       drv0_en, drv1_en;
  logic [7:0] drv0_val, drv1_val;
  wire  [7:0] data_0, data_1;
`ifdef TDP_RAM_COLLISION_DETECT_EN
  logic       collision;
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  assign data_0 = drv0_en ? drv0_val : 8'hzz;
  assign data_1 = drv1_en ? drv1_val : 8'hzz;

  always #5 clk = ~clk;

  tdp_ram_16x8 dut (
    .clk       (clk),
    .rst       (rst),
`ifdef TDP_RAM_COLLISION_DETECT_EN
    .collision (collision),
`endif
    .data_0    (data_0),
    .data_1    (data_1),
    .addr_0    (addr_0),
    .addr_1    (addr_1),
    .we_0      (we_0),
    .we_1      (we_1),
    .re_0      (re_0),
    .re_1      (re_1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic p0(input logic we, input logic re, input logic [3:0] a,
                    input logic en, input logic [7:0] v);
    we_0 = we; re_0 = re; addr_0 = a; drv0_en = en; drv0_val = v;
  endtask

  task automatic p1(input logic we, input logic re, input logic [3:0] a,
                    input logic en, input logic [7:0] v);
    we_1 = we; re_1 = re; addr_1 = a; drv1_en = en; drv1_val = v;
  endtask

  task automatic rd0(input logic [3:0] a, input logic [7:0] exp);
    p0(1'b0, 1'b1, a, 1'b0, 8'h00);
    q0.push_back('{$sformatf("rd0_a%0d", a), exp});
  endtask

  task automatic rd1(input logic [3:0] a, input logic [7:0] exp);
    p1(1'b0, 1'b1, a, 1'b0, 8'h00);
    q1.push_back('{$sformatf("rd1_a%0d", a), exp});
  endtask

  // Advance one edge and, with the strobes still held, compare any read
  // issued on that edge: its data is on the bus one cycle after the address.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk(e.tag, data_0, e.exp);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk(e.tag, data_1, e.exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    p0(1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    p1(1'b0, 1'b0, 4'd0, 1'b0, 8'h00);

    // Reset for two cycles, then read a cleared word.
    tick();
    tick();
    rst = 1'b0;
    rd0(4'd5, 8'h00);
    tick();
`ifdef TDP_RAM_COLLISION_DETECT_EN
    chk("collision_after_reset", {7'd0, collision}, 8'h00);
`endif

    // Interleaved parallel writes: port 0 even, port 1 odd addresses.
    for (int k = 0; k < 8; k++) begin
      p0(1'b1, 1'b0, 4'(2 * k),     1'b1, 8'((2 * k) * (2 * k)));
      p1(1'b1, 1'b0, 4'(2 * k + 1), 1'b1, 8'((2 * k + 1) * (2 * k + 1)));
      tick();
    end

    // Port 0 reads odd descending, port 1 reads even descending.
    for (int k = 0; k < 8; k++) begin
      rd0(4'(15 - 2 * k), 8'((15 - 2 * k) * (15 - 2 * k)));
      rd1(4'(14 - 2 * k), 8'((14 - 2 * k) * (14 - 2 * k)));
      tick();
    end

    // Both ports read the same word; both read registers now hold 0xE1.
    rd0(4'd15, 8'd225);
    rd1(4'd15, 8'd225);
    tick();

    // Bus release: the bench drives the complement of the read registers,
    // so any RAM drive would corrupt the observed value.
    p0(1'b0, 1'b0, 4'd0,  1'b1, 8'h1E);
    p1(1'b1, 1'b1, 4'd10, 1'b1, 8'h1E);
    tick();
    chk("release_idle_0",    data_0, 8'h1E);
    chk("release_illegal_1", data_1, 8'h1E);
    p0(1'b1, 1'b0, 4'd9, 1'b1, 8'h5A);
    p1(1'b0, 1'b0, 4'd0, 1'b1, 8'hA5);
    tick();
    chk("release_write_0", data_0, 8'h5A);
    chk("release_idle_1",  data_1, 8'hA5);
    // Illegal we=re=1 must not have written addr 10; the write to 9 must land.
    rd0(4'd10, 8'd100);
    rd1(4'd9,  8'h5A);
    tick();

    // Same-address write collision: port 0 wins.
    p0(1'b1, 1'b0, 4'd3, 1'b1, 8'hAA);
    p1(1'b1, 1'b0, 4'd3, 1'b1, 8'h55);
    tick();
`ifdef TDP_RAM_COLLISION_DETECT_EN
    chk("collision_pulse", {7'd0, collision}, 8'h01);
`endif
    p0(1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    p1(1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    tick();
`ifdef TDP_RAM_COLLISION_DETECT_EN
    chk("collision_clear", {7'd0, collision}, 8'h00);
`endif
    rd0(4'd3, 8'hAA);
    tick();

    // Read-during-write across ports: old data first, new data next read.
    rd0(4'd7, 8'd49);
    p1(1'b1, 1'b0, 4'd7, 1'b1, 8'h77);
    tick();
    rd0(4'd7, 8'h77);
    p1(1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    tick();

    // Reset wins over a write issued in the same cycle.
    rst = 1'b1;
    p0(1'b1, 1'b0, 4'd2, 1'b1, 8'h99);
    tick();
    rst = 1'b0;
    rd0(4'd2, 8'h00);
    tick();

    p0(1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
